// File: rtl/layer_serializer.sv
// layer_serializer: buffers one layer's neuron outputs and streams them one element per handshake
module layer_serializer #(
  parameter int data_width  = 16,
  parameter int num_neurons = 30,
  parameter int cnt_width   = $clog2(num_neurons)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [num_neurons*data_width-1:0] in_data,
  output logic [data_width-1:0]             out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic                              busy,
  output logic                              overrun
);
  typedef enum logic {IDLE, SEND} state_t;
  localparam logic [cnt_width-1:0] last_idx = cnt_width'(num_neurons - 1);
  state_t                state, state_n;
  logic [cnt_width-1:0]  idx, idx_n;
  logic [data_width-1:0] buf_q [num_neurons];
  logic [data_width-1:0] words [num_neurons];
  logic                  hs, fin, accept, drop;
  logic [data_width-1:0] out_data_n;
  logic                  out_valid_n, out_last_n, overrun_n;
  for (genvar g = 0; g < num_neurons; g++) begin : g_words
    assign words[g] = in_data[g*data_width +: data_width];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      out_data  <= out_data_n;
      out_valid <= out_valid_n;
      out_last  <= out_last_n;
      busy      <= state_n == SEND;
      overrun   <= overrun_n;
    end
  end
  always_ff @(posedge clk)
    if (accept && !rst) buf_q <= words;
  // a new frame is only taken when idle or exactly on the final handshake of the current one
  always_comb begin
    hs      = out_valid & out_ready;
    fin     = hs & (idx == last_idx);
    accept  = in_valid & ((state == IDLE) | fin);
    drop    = in_valid & (state == SEND) & ~fin;
    state_n = accept ? SEND : fin ? IDLE : state;
    idx_n   = (accept | fin) ? '0 : hs ? idx + 1'b1 : idx;
  end
  always_comb begin
    out_data_n  = accept ? words[0] : (state_n == SEND) ? buf_q[idx_n] : out_data;
    out_valid_n = state_n == SEND;
    out_last_n  = out_valid_n & (idx_n == last_idx);
    overrun_n   = overrun | drop;
  end
endmodule

// File: tb/tb_layer_serializer.sv
// tb_layer_serializer: directed plus random stimulus against a frame/position reference model
module tb_layer_serializer;
  localparam int W = 16;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready, out_valid, out_last, busy, overrun;
  logic [N*W-1:0] in_data;
  logic [W-1:0] out_data;
  int tests = 0, fails = 0;
  logic [W-1:0] m_fr [N];
  int m_pos = 0;
  bit m_act = 0, m_ovr = 0;
  layer_serializer #(.data_width(W), .num_neurons(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  task automatic cyc(input bit r, input bit iv, input logic [N*W-1:0] d, input bit rdy);
    bit done;
    rst = r; in_valid = iv; in_data = d; out_ready = rdy;
    @(posedge clk);
    if (r) begin
      m_act = 0; m_pos = 0; m_ovr = 0;
    end else begin
      done = m_act && rdy && m_pos == N-1;
      if (iv && (!m_act || done)) begin
        for (int i = 0; i < N; i++) m_fr[i] = d[i*W +: W];
        m_pos = 0; m_act = 1;
      end else begin
        if (iv) m_ovr = 1;
        if (m_act && rdy) begin
          if (m_pos == N-1) m_act = 0;
          else m_pos++;
        end
      end
    end
    @(negedge clk);
    chk("out_valid", 32'(out_valid), 32'(m_act));
    chk("busy", 32'(busy), 32'(m_act));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("out_last", 32'(out_last), 32'(m_act && m_pos == N-1));
    if (m_act) chk("out_data", 32'(out_data), 32'(m_fr[m_pos]));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, 1);
  endtask
  initial begin
    logic [N*W-1:0] f1, f2, d;
    f1 = 64'h0004_0003_0002_0001;
    f2 = 64'hDDDD_CCCC_BBBB_AAAA;
    rst = 1; in_valid = 0; in_data = '0; out_ready = 1;
    cyc(1, 0, '0, 1); cyc(1, 0, '0, 1);
    idle(2);
    cyc(0, 1, f1, 1); idle(5);
    cyc(0, 1, f1, 1); cyc(0, 0, '0, 1); cyc(0, 0, '0, 0); cyc(0, 0, '0, 0); idle(5);
    cyc(0, 1, f1, 1); idle(3); cyc(0, 1, f2, 1); idle(5);
    cyc(1, 0, '0, 1);
    cyc(0, 1, f1, 1); cyc(0, 1, f2, 1); idle(6);
    cyc(0, 1, f1, 0); cyc(0, 0, '0, 1); cyc(1, 0, '0, 1); idle(2);
    cyc(0, 1, f2, 1); idle(5);
    cyc(1, 1, f1, 1); idle(2);
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom);
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 5) == 0, d, $urandom_range(0, 3) != 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
